key_expansion_ctrl: RTL and testbench
=====================================

// Module: key_expansion_ctrl
// PURPOSE
//  Sequences one key_schedule instance through ROUNDS-1 iterations to expand a master key into all round keys.
//  Each round's output key is fed back as the next input. The upper word of every key is stored in a round-key register file.
//  Sits between the key loader (valid/ready) and the encrypt/decrypt round pipeline, which reads round keys by index.
//  Adds reset, handshake and watchdog around the free-running key_schedule FSM.
// PARAMETERS
//  KEY_SIZE    128  master key width (two words)
//  BLOCK_SIZE  64   word width, round-key width
//  ROUNDS      32   number of round keys produced
//  ADDR_W      5    round-key index width, clog2(ROUNDS)
//  FLUSH_CYC   8    cycles start is held low after reset so key_schedule returns to its wait state
//  TIMEOUT     31   max cycles from start pulse to finished before ERROR
// PORTS
//  clk            in   1            clock, rising edge
//  rst_n          in   1            asynchronous reset, active low
//  key_in         in   KEY_SIZE     master key, {k0 word, l0 word} = {[127:64], [63:0]}
//  key_valid      in   1            master key offered
//  key_ready      out  1            controller accepts key this cycle
//  busy           out  1            expansion in progress
//  keys_ready     out  1            all ROUNDS round keys valid
//  error          out  1            watchdog fired; sticky until the next key is accepted
//  rk_rd_en       in   1            round-key read request
//  rk_addr        in   ADDR_W       round-key index
//  rk_data        out  BLOCK_SIZE   round key, 1-cycle read latency
//  rk_data_valid  out  1            rk_data valid (1 cycle after a read of an already-written index)
// BEHAVIOUR
//  Reset: all outputs 0. State=FLUSH. Written-count wr_cnt=0. Register file contents don't-care.
//  FSM:
//  - FLUSH: ks_start=0 for FLUSH_CYC cycles, then go to IDLE.
//  - IDLE/DONE/ERROR: key_ready=1. On key_valid&key_ready:
//    - latch key_in into cur_key; rk[0]<=key_in[127:64]; wr_cnt<=1.
//    - clear keys_ready and error; round ctr i<=0; go to START.
//  - START: ks_start=1 for exactly one cycle, ks_key=cur_key, ks_round_ctr=i zero-extended to BLOCK_SIZE; go to WAIT.
//  - WAIT: ks_start=0, watchdog counts.
//    - On ks_finished=1: go to STORE.
//    - If the count reaches TIMEOUT without finished: set error, go to ERROR. keys_ready stays 0.
//  - STORE: rk[i+1]<=ks_out_key[127:64]; cur_key<=ks_out_key; wr_cnt<=i+2.
//    - If i==ROUNDS-2: keys_ready<=1, go to DONE.
//    - Else: i<=i+1, go to START.
//  busy=1 in START/WAIT/STORE; key_ready=0 there. A key_valid during busy is not accepted and is held by the sender.
//  ks_round_ctr stays stable from START through STORE. ks_finished is ignored outside WAIT.
//  Latency: key accept to keys_ready = (ROUNDS-1)*(2+ks_lat)+1 cycles, where ks_lat = cycles from start to finished.
//  Read port (independent of FSM, every cycle):
//  - rk_data_valid<=rk_rd_en && rk_addr<wr_cnt; rk_data<=rk[rk_addr] when valid, else 0.
//  - Reads are allowed during expansion and return already-written keys.
//  - rk_addr>=ROUNDS -> valid=0, data=0.
//  Simultaneous STORE write and read of the same index -> returns the old value, valid=0.
//  New key accepted in DONE: wr_cnt drops to 1 in the same edge. A read issued that cycle for index>=1 returns valid=0.
//  Reset mid-expansion -> FLUSH; the sub-FSM drains before any new start.
//  Round counter i is ADDR_W bits and never wraps (max ROUNDS-2).
// STRUCTURE
//  Shared package/header key_expansion_defines.vh:
//  - state encodings KX_FLUSH..KX_ERROR
//  - ROUNDS, FLUSH_CYC, TIMEOUT defaults
//  - word-index macros for key halves
//  Sub-module: u_ks is an instance of key_schedule (KEY_SIZE, BLOCK_SIZE). It is the only instantiated child.
//  Register file: ROUNDS x BLOCK_SIZE flops, one write port, one read port.
// TESTING
//  1 key_in=128'h0706050403020100_0f0e0d0c0b0a0908 -> rk[0]=64'h0706050403020100.
//    rk[1..31] match the golden SPECK128/128 model. keys_ready rises once. busy then falls.
//  2 Reset released, key_valid=1 at cycle 0 -> key_ready=0 for FLUSH_CYC cycles, then accepted. No ks_start during FLUSH.
//  3 Second key_valid while busy -> key_ready=0, no corruption. Accepted in DONE: keys_ready=0 next cycle, rk[0]=new key.
//  4 Read rk_addr=5 at round 2 -> rk_data_valid=0. Read after DONE -> valid=1, data=golden rk[5]. rk_addr=31 after DONE -> valid=1.
//  5 ks_finished forced 0 by bench -> error=1 after TIMEOUT cycles, state ERROR, keys_ready=0. The next key clears error.
//  6 rst_n pulsed low mid-round 10 -> all outputs 0 asynchronously. A fresh key after FLUSH yields correct rk[0..31].

Source files
------------

// File: rtl/key_expansion_ctrl_pkg.sv
// Shared constants for the round-key expansion controller.
// State codes, sizes and key-half helpers.
package key_expansion_ctrl_pkg;

   localparam int KEY_SIZE   = 128;
   localparam int BLOCK_SIZE = 64;
   localparam int ROUNDS     = 32;
   localparam int ADDR_W     = 5;
   localparam int CNT_W      = $clog2(ROUNDS + 1);
   localparam int FLUSH_CYC  = 8;
   localparam int TIMEOUT    = 31;

   localparam logic [2:0] KX_FLUSH = 3'd0;
   localparam logic [2:0] KX_IDLE  = 3'd1;
   localparam logic [2:0] KX_START = 3'd2;
   localparam logic [2:0] KX_WAIT  = 3'd3;
   localparam logic [2:0] KX_STORE = 3'd4;
   localparam logic [2:0] KX_DONE  = 3'd5;
   localparam logic [2:0] KX_ERROR = 3'd6;

   function automatic logic [BLOCK_SIZE-1:0] k_word(
      input logic [KEY_SIZE-1:0] key
   );
      return key[KEY_SIZE-1 -: BLOCK_SIZE];
   endfunction

endpackage

// File: rtl/key_expansion_ctrl_if.sv
// Key loader / round-key read bundle.
// slave faces the controller, master faces its users.
interface key_expansion_ctrl_if;
   import key_expansion_ctrl_pkg::*;

   logic [KEY_SIZE-1:0]   key_in;
   logic                  key_valid;
   logic                  key_ready;
   logic                  busy;
   logic                  keys_ready;
   logic                  error;
   logic                  rk_rd_en;
   logic [ADDR_W-1:0]     rk_addr;
   logic [BLOCK_SIZE-1:0] rk_data;
   logic                  rk_data_valid;

   modport master (
      output key_in, key_valid, rk_rd_en, rk_addr,
      input  key_ready, busy, keys_ready, error,
      input  rk_data, rk_data_valid
   );

   modport slave (
      input  key_in, key_valid, rk_rd_en, rk_addr,
      output key_ready, busy, keys_ready, error,
      output rk_data, rk_data_valid
   );

endinterface

// File: rtl/key_expansion_ctrl_ks.sv
// One SPECK128/128 key-schedule step as a small FSM.
// Latches key and counter on start, pulses finished.
module key_schedule #(
   parameter int KEY_SIZE   = 128,
   parameter int BLOCK_SIZE = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [KEY_SIZE-1:0]   key,
   input  logic [BLOCK_SIZE-1:0] round_ctr,
   output logic [KEY_SIZE-1:0]   out_key,
   output logic                  finished
);

   localparam logic [1:0] KS_IDLE = 2'd0;
   localparam logic [1:0] KS_CALC = 2'd1;
   localparam logic [1:0] KS_FIN  = 2'd2;

   logic [1:0]            state;
   logic [BLOCK_SIZE-1:0] k;
   logic [BLOCK_SIZE-1:0] l;
   logic [BLOCK_SIZE-1:0] ctr;
   logic [BLOCK_SIZE-1:0] l_ror;
   logic [BLOCK_SIZE-1:0] k_rol;
   logic [BLOCK_SIZE-1:0] l_next;
   logic [BLOCK_SIZE-1:0] k_next;

   assign l_ror  = {l[7:0], l[BLOCK_SIZE-1:8]};
   assign k_rol  = {k[BLOCK_SIZE-4:0], k[BLOCK_SIZE-1:BLOCK_SIZE-3]};
   assign l_next = (k + l_ror) ^ ctr;
   assign k_next = k_rol ^ l_next;

   assign finished = (state == KS_FIN);

   // latch operands, compute one step, signal completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= KS_IDLE;
         k       <= '0;
         l       <= '0;
         ctr     <= '0;
         out_key <= '0;
      end else begin
         case (state)
            KS_IDLE: begin
               if (start) begin
                  k     <= key[KEY_SIZE-1 -: BLOCK_SIZE];
                  l     <= key[BLOCK_SIZE-1:0];
                  ctr   <= round_ctr;
                  state <= KS_CALC;
               end
            end
            KS_CALC: begin
               out_key <= {k_next, l_next};
               state   <= KS_FIN;
            end
            default: state <= KS_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/key_expansion_ctrl.sv
// Drives key_schedule ROUNDS-1 times and keeps the upper
// word of every key in a round-key file with a read port.
module key_expansion_ctrl
   import key_expansion_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   key_expansion_ctrl_if.slave bus
);

   localparam int FL_W = $clog2(FLUSH_CYC);
   localparam int WD_W = $clog2(TIMEOUT + 1);

   logic [2:0]            state;
   logic [FL_W-1:0]       flush_cnt;
   logic [WD_W-1:0]       wd_cnt;
   logic [ADDR_W-1:0]     rnd;
   logic [CNT_W-1:0]      wr_cnt;
   logic [KEY_SIZE-1:0]   cur_key;
   logic [BLOCK_SIZE-1:0] rk [ROUNDS];

   logic                  ks_start;
   logic                  ks_finished;
   logic [KEY_SIZE-1:0]   ks_out_key;
   logic [BLOCK_SIZE-1:0] ks_round_ctr;

   logic                  accept;
   logic [CNT_W-1:0]      rd_lim;
   logic                  rd_hit;

   assign bus.key_ready = (state == KX_IDLE) ||
                          (state == KX_DONE) ||
                          (state == KX_ERROR);
   assign bus.busy      = (state == KX_START) ||
                          (state == KX_WAIT) ||
                          (state == KX_STORE);
   assign accept        = bus.key_ready && bus.key_valid;
   assign ks_start      = (state == KX_START);
   assign ks_round_ctr  = BLOCK_SIZE'(rnd);

   key_schedule #(
      .KEY_SIZE   (KEY_SIZE),
      .BLOCK_SIZE (BLOCK_SIZE)
   ) u_ks (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (ks_start),
      .key       (cur_key),
      .round_ctr (ks_round_ctr),
      .out_key   (ks_out_key),
      .finished  (ks_finished)
   );

   // sequencing FSM with flush, watchdog and status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= KX_FLUSH;
         flush_cnt      <= '0;
         wd_cnt         <= '0;
         rnd            <= '0;
         wr_cnt         <= '0;
         cur_key        <= '0;
         bus.keys_ready <= 1'b0;
         bus.error      <= 1'b0;
      end else begin
         case (state)
            KX_FLUSH: begin
               if (flush_cnt == FL_W'(FLUSH_CYC - 1))
                  state <= KX_IDLE;
               else
                  flush_cnt <= flush_cnt + 1'b1;
            end
            KX_IDLE, KX_DONE, KX_ERROR: begin
               if (bus.key_valid) begin
                  cur_key        <= bus.key_in;
                  wr_cnt         <= CNT_W'(1);
                  bus.keys_ready <= 1'b0;
                  bus.error      <= 1'b0;
                  rnd            <= '0;
                  state          <= KX_START;
               end
            end
            KX_START: begin
               wd_cnt <= '0;
               state  <= KX_WAIT;
            end
            KX_WAIT: begin
               if (ks_finished) begin
                  state <= KX_STORE;
               end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                  bus.error <= 1'b1;
                  state     <= KX_ERROR;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            KX_STORE: begin
               cur_key <= ks_out_key;
               wr_cnt  <= CNT_W'(rnd) + CNT_W'(2);
               if (rnd == ADDR_W'(ROUNDS - 2)) begin
                  bus.keys_ready <= 1'b1;
                  state          <= KX_DONE;
               end else begin
                  rnd   <= rnd + ADDR_W'(1);
                  state <= KX_START;
               end
            end
            default: state <= KX_FLUSH;
         endcase
      end
   end

   // round-key file write port: master word on accept, then each step
   always_ff @(posedge clk) begin
      if (accept)
         rk[0] <= k_word(bus.key_in);
      else if (state == KX_STORE)
         rk[rnd + ADDR_W'(1)] <= k_word(ks_out_key);
   end

   // an index being written this edge reads as not yet valid
   assign rd_lim = accept ? '0 : wr_cnt;
   assign rd_hit = bus.rk_rd_en && (CNT_W'(bus.rk_addr) < rd_lim);

   // registered read port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rk_data_valid <= 1'b0;
         bus.rk_data       <= '0;
      end else begin
         bus.rk_data_valid <= rd_hit;
         bus.rk_data       <= rd_hit ? rk[bus.rk_addr] : '0;
      end
   end

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// Self-checking bench for key_expansion_ctrl against a
// SPECK128/128 key-schedule reference computed here.
module tb_key_expansion_ctrl;
   import key_expansion_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   logic [63:0]  mdl [ROUNDS];
   logic [127:0] k1;
   logic [127:0] k2;

   key_expansion_ctrl_if bus ();

   key_expansion_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   task automatic model_keys(input logic [127:0] key);
      logic [63:0] a;
      logic [63:0] b;
      a = key[127:64];
      b = key[63:0];
      mdl[0] = a;
      for (int i = 0; i < ROUNDS - 1; i++) begin
         b = (a + rotr(b, 8)) ^ 64'(i);
         a = rotr(a, 61) ^ b;
         mdl[i + 1] = a;
      end
   endtask

   function automatic logic [127:0] rand_key();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic accept_key(input string tag, input logic [127:0] k);
      bus.key_in = k;
      bus.key_valid = 1'b1;
      for (int n = 0; n < 40 && bus.key_ready !== 1'b1; n++)
         @(negedge clk);
      chk({tag, "_key_ready"}, 64'(bus.key_ready), 1);
      @(negedge clk);
      bus.key_valid = 1'b0;
      model_keys(k);
      chk({tag, "_busy"}, 64'(bus.busy), 1);
   endtask

   task automatic wait_ready(input string tag, input bit rnd_rd);
      int a;
      int hi;
      a = 0;
      hi = 0;
      for (int n = 0; n < 400 && bus.keys_ready !== 1'b1; n++) begin
         if (rnd_rd) begin
            a = $urandom_range(0, ROUNDS - 1);
            bus.rk_rd_en = 1'b1;
            bus.rk_addr = ADDR_W'(a);
         end
         @(negedge clk);
         if (rnd_rd) begin
            if (a <= hi)
               chk({tag, "_rd_old_valid"}, 64'(bus.rk_data_valid), 1);
            if (bus.rk_data_valid === 1'b1) begin
               chk({tag, "_rd_data"}, bus.rk_data, mdl[a]);
               if (a > hi) hi = a;
            end else begin
               chk({tag, "_rd_zero"}, bus.rk_data, 0);
            end
         end
      end
      bus.rk_rd_en = 1'b0;
      chk({tag, "_keys_ready"}, 64'(bus.keys_ready), 1);
      chk({tag, "_busy_low"}, 64'(bus.busy), 0);
      @(negedge clk);
      chk({tag, "_keys_ready_hold"}, 64'(bus.keys_ready), 1);
   endtask

   task automatic verify_all(input string tag);
      for (int a = 0; a < ROUNDS; a++) begin
         bus.rk_rd_en = 1'b1;
         bus.rk_addr = ADDR_W'(a);
         @(negedge clk);
         chk($sformatf("%s_rk%0d_valid", tag, a),
             64'(bus.rk_data_valid), 1);
         chk($sformatf("%s_rk%0d", tag, a), bus.rk_data, mdl[a]);
      end
      bus.rk_rd_en = 1'b0;
      @(negedge clk);
      chk({tag, "_no_rd"}, 64'(bus.rk_data_valid), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: observed=stuck expected=finish");
      $fatal(1, "simulation time limit");
   end

   initial begin
      k1 = 128'h0706050403020100_0f0e0d0c0b0a0908;
      bus.key_in = k1;
      bus.key_valid = 1'b1;
      bus.rk_rd_en = 1'b0;
      bus.rk_addr = '0;

      @(negedge clk);
      @(negedge clk);
      chk("rst_key_ready", 64'(bus.key_ready), 0);
      chk("rst_busy", 64'(bus.busy), 0);
      chk("rst_keys_ready", 64'(bus.keys_ready), 0);
      chk("rst_error", 64'(bus.error), 0);
      chk("rst_rd_valid", 64'(bus.rk_data_valid), 0);
      chk("rst_rd_data", bus.rk_data, 0);

      rst_n = 1'b1;
      for (int i = 0; i < FLUSH_CYC; i++) begin
         chk($sformatf("flush%0d_key_ready", i), 64'(bus.key_ready), 0);
         chk($sformatf("flush%0d_ks_start", i), 64'(dut.ks_start), 0);
         @(negedge clk);
      end
      chk("flush_end_key_ready", 64'(bus.key_ready), 1);

      accept_key("k1", k1);
      chk("k1_key_ready_low", 64'(bus.key_ready), 0);
      bus.rk_rd_en = 1'b1;
      bus.rk_addr = ADDR_W'(5);
      @(negedge clk);
      chk("early_rd5_valid", 64'(bus.rk_data_valid), 0);
      chk("early_rd5_data", bus.rk_data, 0);
      bus.rk_addr = ADDR_W'(0);
      @(negedge clk);
      chk("early_rd0_valid", 64'(bus.rk_data_valid), 1);
      chk("early_rd0_data", bus.rk_data, 64'h0706050403020100);
      bus.rk_rd_en = 1'b0;
      wait_ready("k1", 1'b0);
      verify_all("k1");

      k2 = rand_key();
      bus.key_in = k2;
      bus.key_valid = 1'b1;
      bus.rk_rd_en = 1'b1;
      bus.rk_addr = ADDR_W'(1);
      @(negedge clk);
      model_keys(k2);
      chk("k2_keys_ready_clr", 64'(bus.keys_ready), 0);
      chk("k2_busy", 64'(bus.busy), 1);
      chk("k2_rd_on_accept", 64'(bus.rk_data_valid), 0);
      bus.rk_rd_en = 1'b0;
      bus.key_in = rand_key();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("k3_held%0d_key_ready", i), 64'(bus.key_ready), 0);
      end
      bus.key_valid = 1'b0;
      wait_ready("k2", 1'b1);
      verify_all("k2");

      force dut.ks_finished = 1'b0;
      accept_key("wd", rand_key());
      for (int n = 0; n < 100 && bus.error !== 1'b1; n++)
         @(negedge clk);
      chk("wd_error", 64'(bus.error), 1);
      chk("wd_keys_ready", 64'(bus.keys_ready), 0);
      chk("wd_busy", 64'(bus.busy), 0);
      chk("wd_key_ready", 64'(bus.key_ready), 1);
      bus.rk_rd_en = 1'b1;
      bus.rk_addr = ADDR_W'(1);
      @(negedge clk);
      bus.rk_rd_en = 1'b0;
      chk("wd_rd1_valid", 64'(bus.rk_data_valid), 0);
      repeat (3) @(negedge clk);
      chk("wd_error_sticky", 64'(bus.error), 1);
      release dut.ks_finished;
      accept_key("k5", rand_key());
      chk("k5_error_clr", 64'(bus.error), 0);
      wait_ready("k5", 1'b1);
      verify_all("k5");

      accept_key("k6", rand_key());
      repeat (40) @(negedge clk);
      chk("k6_mid_busy", 64'(bus.busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", 64'(bus.busy), 0);
      chk("arst_key_ready", 64'(bus.key_ready), 0);
      chk("arst_keys_ready", 64'(bus.keys_ready), 0);
      chk("arst_error", 64'(bus.error), 0);
      chk("arst_rd_valid", 64'(bus.rk_data_valid), 0);
      chk("arst_rd_data", bus.rk_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("k7_flush_ks_start", 64'(dut.ks_start), 0);
      accept_key("k7", rand_key());
      wait_ready("k7", 1'b1);
      verify_all("k7");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
